instr_fetch_queue: RTL

- Fetch stage feeding the single-cycle RISC-V core's `instruction` input.
- Generates sequential PCs and issues word reads to instruction memory over a valid/ready request channel.
- Collects in-order read responses into a DEPTH-entry queue and presents {instr, pc} to the core with a valid/ready handshake.
- Accepts redirects (taken beq, jal) from the core: flushes the queue, discards stale in-flight responses and restarts fetch at the new PC.

---
 rtl/instr_fetch_queue.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch stage for the single-cycle RISC-V core. It generates sequential
//   word PCs, issues reads to instruction memory over a valid/ready request
//   channel, collects the in-order responses into a DEPTH-entry queue, and
//   presents {instr, instr_pc} to the core with a valid/ready handshake.
//   A redirect flushes the queue, arranges for stale in-flight responses to
//   be discarded, and restarts fetch at the new (word-aligned) PC.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   mem_req_*       request channel: valid/ready handshake, word address
//   mem_rsp_*       in-order read responses (valid + data)
//   instr_*         queue head to the core: valid/ready, instruction, its PC
//   redirect_*      one-cycle redirect pulse and new fetch target
//   busy            requests outstanding or discards still pending
module instr_fetch_queue #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [CW:0]           DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  // Queue storage (no reset needed: the head is gated by instr_valid)
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q,   rsp_pc_d;
  logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]         count_q,    count_d;
  logic [CW-1:0]         outst_q,    outst_d;
  logic [CW-1:0]         drop_q,     drop_d;

  logic [CW:0]           used;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redirect_aligned;

  // Credit check: every queued entry and every in-flight request holds one
  // slot, so a returning response always has room.
  assign used          = {1'b0, count_q} + {1'b0, outst_q};
  assign mem_req_valid = !rst && (used < DEPTH_W);
  assign mem_req_addr  = fetch_pc_q;

  assign req_fire = mem_req_valid & mem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = mem_rsp_valid & (outst_q != '0);
  assign pop      = instr_valid & instr_ready;
  assign push     = rsp_fire & (drop_q == '0) & ~redirect_valid;

  assign redirect_aligned = redirect_pc & ALIGN_MK;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr_q]   : '0;
  assign busy        = (outst_q != '0) | (drop_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);
    count_d    = count_q + CW'(push) - CW'(pop);

    if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      rsp_pc_d = rsp_pc_q + PC_STEP;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);

    // Redirect overrides everything above. Every request still in flight
    // after this edge (including one accepted now) belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rsp_data;
      pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  a_rsp_needs_outstanding: assert property (
    @(posedge clk) disable iff (rst) mem_rsp_valid |-> (outst_q != '0)
  );

endmodule
